// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demux with per-channel valid/ready and select or TDM round-robin steering
module demux4_reg #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           tdm,
  input  logic           sync,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [1:0]     slot
);
  logic [4*W-1:0] data_q, data_d;
  logic [3:0]     valid_q, valid_d;
  logic [1:0]     slot_q, slot_d;
  logic [1:0]     dest;
  logic           accept;
  always_comb begin
    dest = tdm ? (sync ? 2'd0 : slot_q) : in_sel;
    in_ready = !valid_q[dest] || out_ready[dest];
    accept = in_valid && in_ready;
    valid_d = valid_q & ~out_ready;
    data_d = data_q;
    if (accept) begin
      valid_d[dest] = 1'b1;
      data_d[dest*W +: W] = in_data;
    end
    slot_d = !tdm ? slot_q : sync ? {1'b0, accept} : slot_q + {1'b0, accept};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      valid_q <= '0;
      slot_q <= '0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      slot_q <= slot_d;
    end
  end
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign slot = slot_q;
endmodule
